move_deque: RTL and testbench

- Parametrised double-ended queue: a circular buffer with independent head and tail pointers.
- Supports push and pop at both ends, exact occupancy count, full/empty flags and sticky error flags.
- Successor to the fixed 2-bit x 256 move store in the maze-solver datapath.
- Sits beside the X/Y position registers and holds move history for backtracking (pop_back) and replay (pop_front).

---
 rtl/move_deque.sv | 141 ++++++++++++++
 tb/tb_move_deque.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_deque.sv
// Parametrised double-ended queue (circular buffer) holding maze-solver move history.
// Optional MOVE_DEQUE_PEEK_EN adds combinational peek_front/peek_back outputs.
module move_deque #(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              our_reset,
    input  logic              clear,
    input  logic              push_front,
    input  logic              push_back,
    input  logic              pop_front,
    input  logic              pop_back,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow,
    output logic              illegal
`ifdef MOVE_DEQUE_PEEK_EN
    ,
    output logic [DATA_W-1:0] peek_front,
    output logic [DATA_W-1:0] peek_back
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d, tail_m1;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              illegal_q, illegal_d;

    logic push_f_req, push_b_req, pop_f_req, pop_b_req;
    logic push_req, pop_req, push_ok, pop_ok;
    logic do_push_f, do_push_b, do_pop_f, do_pop_b;
    logic is_empty, is_full;

    // Request decode, acceptance and next-state computation
    always_comb begin
        push_f_req  = push_front & ~push_back;
        push_b_req  = push_back & ~push_front;
        pop_f_req   = pop_front & ~pop_back;
        pop_b_req   = pop_back & ~pop_front;
        push_req    = push_f_req | push_b_req;
        pop_req     = pop_f_req | pop_b_req;
        is_empty    = (count_q == '0);
        is_full     = (count_q == CNT_W'(DEPTH));
        tail_m1     = tail_q - ADDR_W'(1);

        // A pop on a full queue frees the slot the concurrent push uses
        pop_ok      = pop_req & ~is_empty;
        push_ok     = push_req & (~is_full | pop_ok);
        do_push_f   = push_f_req & push_ok;
        do_push_b   = push_b_req & push_ok;
        do_pop_f    = pop_f_req & pop_ok;
        do_pop_b    = pop_b_req & pop_ok;

        head_d = head_q;
        if (do_push_f) head_d = head_d - ADDR_W'(1);
        if (do_pop_f)  head_d = head_d + ADDR_W'(1);
        tail_d = tail_q;
        if (do_push_b) tail_d = tail_d + ADDR_W'(1);
        if (do_pop_b)  tail_d = tail_d - ADDR_W'(1);

        count_d = count_q;
        if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);

        // Write lands at the new front, or one below the new back
        rd_addr = do_pop_b ? tail_m1 : head_q;
        wr_addr = do_push_b ? (tail_d - ADDR_W'(1)) : head_d;

        dout_d      = pop_ok ? mem_q[rd_addr] : dout_q;
        overflow_d  = overflow_q | (push_req & ~push_ok);
        underflow_d = underflow_q | (pop_req & is_empty);
        illegal_d   = illegal_q | (push_front & push_back) | (pop_front & pop_back);
    end

    always_ff @(posedge Clk or negedge our_reset) begin
        if (!our_reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (clear) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= pop_ok;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            illegal_q    <= illegal_d;
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge Clk) begin
        if (our_reset && !clear && push_ok) begin
            mem_q[wr_addr] <= din;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign count      = count_q;
    assign full       = is_full;
    assign empty      = is_empty;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign illegal    = illegal_q;

`ifdef MOVE_DEQUE_PEEK_EN
    assign peek_front = is_empty ? '0 : mem_q[head_q];
    assign peek_back  = is_empty ? '0 : mem_q[tail_m1];
`endif

endmodule

// File: tb/tb_move_deque.sv
// Self-checking bench for move_deque (DEPTH=4) against a queue-based reference model.
module tb_move_deque;

    localparam int unsigned DW    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic          Clk, our_reset, clear;
    logic          push_front, push_back, pop_front, pop_back;
    logic [DW-1:0] din, dout;
    logic          dout_valid;
    logic [AW:0]   count;
    logic          full, empty, overflow, underflow, illegal;
`ifdef MOVE_DEQUE_PEEK_EN
    logic [DW-1:0] peek_front, peek_back;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, front at index 0
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    logic          m_valid, m_ov, m_un, m_il;

    move_deque #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .Clk        (Clk),
        .our_reset  (our_reset),
        .clear      (clear),
        .push_front (push_front),
        .push_back  (push_back),
        .pop_front  (pop_front),
        .pop_back   (pop_back),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow),
        .illegal    (illegal)
`ifdef MOVE_DEQUE_PEEK_EN
        ,
        .peek_front (peek_front),
        .peek_back  (peek_back)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_reset();
        mq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ov    = 1'b0;
        m_un    = 1'b0;
        m_il    = 1'b0;
    endtask

    task automatic model_step(input logic pf, pb, qf, qb, input logic [DW-1:0] d, input logic clr);
        if (clr) begin
            model_reset();
            return;
        end
        m_valid = 1'b0;
        if ((pf && pb) || (qf && qb)) m_il = 1'b1;
        if (qf ^ qb) begin
            if (mq.size() == 0) m_un = 1'b1;
            else begin
                m_dout  = qf ? mq.pop_front() : mq.pop_back();
                m_valid = 1'b1;
            end
        end
        if (pf ^ pb) begin
            if (mq.size() == DEPTH) m_ov = 1'b1;
            else if (pf) mq.push_front(d);
            else mq.push_back(d);
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, settle 1ns after
    task automatic drive(input logic pf, pb, qf, qb, input logic [DW-1:0] d, input logic clr);
        push_front = pf; push_back = pb; pop_front = qf; pop_back = qb;
        din = d; clear = clr;
        @(posedge Clk);
        model_step(pf, pb, qf, qb, d, clr);
        #1;
        push_front = 0; push_back = 0; pop_front = 0; pop_back = 0; clear = 0;
    endtask

    task automatic test_reset();
        our_reset = 1'b0; clear = 0; din = '0;
        push_front = 0; push_back = 0; pop_front = 0; pop_back = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_occupancy: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full);
        end
        checks++;
        if (dout !== '0 || dout_valid !== 1'b0 || {overflow, underflow, illegal} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got dout=%0d valid=%b flags=%b%b%b expected 0/0/000",
                     dout, dout_valid, overflow, underflow, illegal);
        end
        #3 our_reset = 1'b1;
    endtask

    task automatic test_fifo_order();
        logic [DW-1:0] exp_v [3];
        exp_v[0] = 4'd1; exp_v[1] = 4'd2; exp_v[2] = 4'd3;
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, exp_v[i], 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, '0, 0);
            checks++;
            if (dout !== exp_v[i] || dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL fifo_pop%0d: got dout=%0d valid=%b expected %0d/1", i, dout, dout_valid, exp_v[i]);
            end
        end
        drive(0, 0, 0, 0, '0, 0);
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL fifo_drained: got count=%0d empty=%b valid=%b expected 0/1/0", count, empty, dout_valid);
        end
    endtask

    task automatic test_mixed_ends();
        logic [DW-1:0] exp_v [3];
        exp_v[0] = 4'd2; exp_v[1] = 4'd1; exp_v[2] = 4'd3;
        drive(0, 1, 0, 0, 4'd1, 0);
        drive(0, 1, 0, 0, 4'd2, 0);
        drive(1, 0, 0, 0, 4'd3, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, '0, 0);
            checks++;
            if (dout !== exp_v[i] || dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL mixed_pop_back%0d: got dout=%0d valid=%b expected %0d/1", i, dout, dout_valid, exp_v[i]);
            end
        end
        checks++;
        if ({overflow, underflow, illegal} !== 3'b000 || count !== 3'd0) begin
            errors++;
            $display("FAIL mixed_flags: got flags=%b%b%b count=%0d expected 000/0", overflow, underflow, illegal, count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, DW'(i), 0);
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_reached: got full=%b count=%0d ovf=%b expected 1/4/0", full, count, overflow);
        end
        drive(0, 1, 0, 0, 4'd9, 0);
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("FAIL full_overflow: got ovf=%b count=%0d expected 1/4", overflow, count);
        end
        drive(0, 1, 1, 0, 4'd2, 0);
        checks++;
        if (dout !== 4'd0 || dout_valid !== 1'b1 || count !== 3'd4 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: got dout=%0d valid=%b count=%0d full=%b expected 0/1/4/1",
                     dout, dout_valid, count, full);
        end
        // Remaining contents must be 1,2,3,2 front to back
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0, '0, 0);
            checks++;
            if (dout !== ((i == 3) ? 4'd2 : DW'(i + 1))) begin
                errors++;
                $display("FAIL full_drain%0d: got dout=%0d expected %0d", i, dout, (i == 3) ? 2 : i + 1);
            end
        end
        drive(0, 0, 0, 0, '0, 1);
    endtask

    task automatic test_wrap();
        logic [DW-1:0] prev;
        prev = 4'hF;
        drive(0, 1, 0, 0, prev, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, 0, DW'(i), 0);
            checks++;
            if (dout !== prev || dout_valid !== 1'b1 || count !== 3'd1) begin
                errors++;
                $display("FAIL wrap%0d: got dout=%0d valid=%b count=%0d expected %0d/1/1", i, dout, dout_valid, count, prev);
            end
            prev = DW'(i);
        end
        drive(0, 0, 0, 0, '0, 1);
    endtask

    task automatic test_empty();
        drive(0, 0, 0, 1, '0, 0);
        checks++;
        if (underflow !== 1'b1 || dout_valid !== 1'b0 || dout !== '0) begin
            errors++;
            $display("FAIL empty_pop: got unf=%b valid=%b dout=%0d expected 1/0/0", underflow, dout_valid, dout);
        end
        drive(0, 1, 1, 0, 4'd2, 0);
        checks++;
        if (underflow !== 1'b1 || count !== 3'd1 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_pop_push: got unf=%b count=%0d valid=%b expected 1/1/0", underflow, count, dout_valid);
        end
        drive(0, 0, 1, 1, '0, 0);
        checks++;
        if (illegal !== 1'b1 || count !== 3'd1 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_pops: got ill=%b count=%0d valid=%b expected 1/1/0", illegal, count, dout_valid);
        end
        drive(1, 1, 0, 1, 4'd7, 0);
        checks++;
        if (count !== 3'd0 || dout !== 4'd2 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL both_pushes_pop: got count=%0d dout=%0d valid=%b expected 0/2/1", count, dout, dout_valid);
        end
    endtask

    task automatic test_async_reset_clear();
        drive(0, 1, 0, 0, 4'd5, 0);
        drive(1, 0, 0, 0, 4'd6, 0);
        drive(0, 1, 0, 0, 4'd7, 0);
        #2 our_reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || {overflow, underflow, illegal} !== 3'b000 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got count=%0d empty=%b flags=%b%b%b valid=%b expected 0/1/000/0",
                     count, empty, overflow, underflow, illegal, dout_valid);
        end
        #1 our_reset = 1'b1;
        drive(0, 1, 0, 0, 4'd3, 0);
        drive(0, 1, 0, 0, 4'd4, 0);
        drive(0, 0, 1, 1, '0, 0);
        drive(0, 0, 1, 0, '0, 0);
        checks++;
        if (count !== 3'd1 || illegal !== 1'b1 || dout !== 4'd3) begin
            errors++;
            $display("FAIL pre_clear: got count=%0d ill=%b dout=%0d expected 1/1/3", count, illegal, dout);
        end
        drive(0, 1, 1, 0, 4'd8, 1);
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || {overflow, underflow, illegal} !== 3'b000 ||
            dout !== '0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear: got count=%0d empty=%b flags=%b%b%b dout=%0d valid=%b expected 0/1/000/0/0",
                     count, empty, overflow, underflow, illegal, dout, dout_valid);
        end
    endtask

    task automatic test_random();
        logic pf, pb, qf, qb, clr;
        logic [DW-1:0] d;
        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 99) < 2);
            pf  = ($urandom_range(0, 99) < 30);
            pb  = ($urandom_range(0, 99) < 30);
            qf  = ($urandom_range(0, 99) < 30);
            qb  = ($urandom_range(0, 99) < 30);
            d   = DW'($urandom);
            drive(pf, pb, qf, qb, d, clr);
            checks++;
            if (dout !== m_dout || dout_valid !== m_valid) begin
                errors++;
                $display("FAIL rand_dout[%0d]: got %0d/%b expected %0d/%b", i, dout, dout_valid, m_dout, m_valid);
            end
            checks++;
            if (count !== (AW + 1)'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
                errors++;
                $display("FAIL rand_count[%0d]: got %0d/%b/%b expected %0d", i, count, empty, full, mq.size());
            end
            checks++;
            if ({overflow, underflow, illegal} !== {m_ov, m_un, m_il}) begin
                errors++;
                $display("FAIL rand_flags[%0d]: got %b%b%b expected %b%b%b", i,
                         overflow, underflow, illegal, m_ov, m_un, m_il);
            end
`ifdef MOVE_DEQUE_PEEK_EN
            checks++;
            if (peek_front !== ((mq.size() == 0) ? '0 : mq[0]) ||
                peek_back !== ((mq.size() == 0) ? '0 : mq[mq.size() - 1])) begin
                errors++;
                $display("FAIL rand_peek[%0d]: got %0d/%0d", i, peek_front, peek_back);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_mixed_ends();
        test_full();
        test_wrap();
        test_empty();
        test_async_reset_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
